// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared FSM state type, default element width and index-width helper
package matmul_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam int DEFAULT_W = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_buffer.sv
// rtl/result_buffer.sv - N x N element store with per-element valid bits and a full flag
module result_buffer
    import matmul_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = DEFAULT_W,
    parameter int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_i,
    input  logic [IW-1:0] wr_j,
    input  logic [W-1:0]  wr_data,
    input  logic          clr_valid,
    input  logic [IW-1:0] rd_i,
    input  logic [IW-1:0] rd_j,
    output logic [W-1:0]  rd_data,
    output logic          full
);

    logic [W-1:0]   mem_q [N][N];
    logic [W-1:0]   mem_d [N][N];
    logic [N*N-1:0] valid_q;
    logic [N*N-1:0] valid_d;
    logic           full_q;
    logic           full_d;
    logic           wr_ok;

    // Out-of-range indices only exist when N is not a power of two
    assign wr_ok = wr_en
                && ({1'b0, wr_i} < (IW+1)'(N))
                && ({1'b0, wr_j} < (IW+1)'(N));

    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (wr_ok) begin
            mem_d[wr_i][wr_j]                  = wr_data;
            valid_d[int'(wr_i) * N + int'(wr_j)] = 1'b1;
        end
        if (clr_valid) begin
            valid_d = '0;
        end
        full_d = &valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            full_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            full_q  <= full_d;
        end
    end

    // Data is deliberately left unreset; the valid bits gate its use
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_i][rd_j];
    assign full    = full_q;

endmodule

// File: rtl/result_streamer.sv
// rtl/result_streamer.sv - buffers an N x N result matrix and streams it out (RESULT_STREAMER_TRANSPOSE_EN selects column-major order)
module result_streamer
    import matmul_pkg::*;
#(
    parameter int N = 8,
    parameter int W = DEFAULT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [idx_w(N)-1:0]   wr_i,
    input  logic [idx_w(N)-1:0]   wr_j,
    input  logic [W-1:0]          wr_data,
    input  logic                  start,
    output logic [W-1:0]          value,
    output logic                  value_stb,
    input  logic                  value_ack,
    output logic [idx_w(N)-1:0]   i,
    output logic [idx_w(N)-1:0]   j,
    output logic                  busy,
    output logic                  full,
    output logic                  done
);

    localparam int IW = idx_w(N);

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic          buf_wr_en;
    logic          clr_valid;
    logic          buf_full;
    logic [W-1:0]  rd_data;
    logic          i_last;
    logic          j_last;

    assign i_last = (i_q == IW'(N - 1));
    assign j_last = (j_q == IW'(N - 1));

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        buf_wr_en = 1'b0;
        clr_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                buf_wr_en = wr_en;
                if (start && buf_full) begin
                    state_d = S_STREAM;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            S_STREAM: begin
                if (value_ack) begin
                    if (i_last && j_last) begin
                        state_d = S_DONE;
                        i_d     = '0;
                        j_d     = '0;
                    end else begin
`ifdef RESULT_STREAMER_TRANSPOSE_EN
                        if (i_last) begin
                            i_d = '0;
                            j_d = j_q + 1'b1;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
`else
                        if (j_last) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
`endif
                    end
                end
            end
            S_DONE: begin
                clr_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    result_buffer #(
        .N  (N),
        .W  (W),
        .IW (IW)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (buf_wr_en),
        .wr_i      (wr_i),
        .wr_j      (wr_j),
        .wr_data   (wr_data),
        .clr_valid (clr_valid),
        .rd_i      (i_q),
        .rd_j      (j_q),
        .rd_data   (rd_data),
        .full      (buf_full)
    );

    // Value is forced to zero outside streaming so unreset storage never leaks out
    assign value_stb = (state_q == S_STREAM);
    assign value     = value_stb ? rd_data : '0;
    assign i         = i_q;
    assign j         = j_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign full      = buf_full;

endmodule

// File: tb/tb_result_streamer.sv
// tb/tb_result_streamer.sv - directed self-checking bench for result_streamer with N=4
module tb_result_streamer;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_i = '0;
    logic [1:0]   wr_j = '0;
    logic [W-1:0] wr_data = '0;
    logic         start = 1'b0;
    logic         value_ack = 1'b0;
    logic [W-1:0] value;
    logic         value_stb;
    logic [1:0]   i;
    logic [1:0]   j;
    logic         busy;
    logic         full;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    result_streamer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_i      (wr_i),
        .wr_j      (wr_j),
        .wr_data   (wr_data),
        .start     (start),
        .value     (value),
        .value_stb (value_stb),
        .value_ack (value_ack),
        .i         (i),
        .j         (j),
        .busy      (busy),
        .full      (full),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elem(input int r, input int c, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_i    = 2'(r);
        wr_j    = 2'(c);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_all(input logic [W-1:0] base);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                write_elem(r, c, base + W'(16 * r + c));
    endtask

    function automatic int exp_row(input int k);
`ifdef RESULT_STREAMER_TRANSPOSE_EN
        return k % N;
`else
        return k / N;
`endif
    endfunction

    function automatic int exp_col(input int k);
`ifdef RESULT_STREAMER_TRANSPOSE_EN
        return k / N;
`else
        return k % N;
`endif
    endfunction

    task automatic check_elem(input string tag, input int k, input logic [W-1:0] base);
        check_eq({tag, "_stb"}, value_stb, 1'b1);
        check_eq({tag, "_value"}, value, base + W'(16 * exp_row(k) + exp_col(k)));
        check_eq({tag, "_i"}, i, exp_row(k));
        check_eq({tag, "_j"}, j, exp_col(k));
    endtask

    logic [7:0] ack_pat;
    int         idx;
    logic       got_done;

    initial begin
        ack_pat = 8'b0100_1101;

        // reset state
        tick();
        tick();
        check_eq("rst_stb", value_stb, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_full", full, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_ij", {i, j}, 4'h0);
        check_eq("rst_value", value, 32'h0);
        rst_n = 1'b1;
        tick();

        // 15 unique elements plus a rewrite must not count as full
        write_elem(0, 0, 32'hDEAD);
        for (int k = 0; k < 15; k++)
            write_elem(k / N, k % N, W'(16 * (k / N) + k % N));
        check_eq("partial_full", full, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("partial_start_stb", value_stb, 1'b0);
        check_eq("partial_start_busy", busy, 1'b0);

        write_elem(3, 3, 32'h33);
        check_eq("load_full", full, 1'b1);

        // ack held high: one element per cycle, done 17 cycles after start
        start     = 1'b1;
        value_ack = 1'b1;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            tick();
            start   = 1'b0;
            wr_en   = (cyc < 16);
            wr_i    = 2'd3;
            wr_j    = 2'd3;
            wr_data = 32'hFF;
            if (cyc <= 16) begin
                check_elem("seq", cyc - 1, 32'h0);
                check_eq("seq_busy", busy, 1'b1);
                check_eq("seq_done", done, 1'b0);
            end else if (cyc == 17) begin
                check_eq("done_pulse", done, 1'b1);
                check_eq("done_stb", value_stb, 1'b0);
                check_eq("done_busy", busy, 1'b1);
            end else begin
                check_eq("post_done", done, 1'b0);
                check_eq("post_busy", busy, 1'b0);
                check_eq("post_full", full, 1'b0);
            end
        end
        wr_en     = 1'b0;
        value_ack = 1'b0;

        // start with an emptied buffer is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("empty_start_stb", value_stb, 1'b0);
        check_eq("empty_start_busy", busy, 1'b0);

        // irregular ack pattern
        load_all(32'h100);
        start = 1'b1;
        tick();
        start    = 1'b0;
        idx      = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (idx == N * N) begin
                check_eq("gap_done", done, 1'b1);
                got_done = 1'b1;
                break;
            end
            check_elem("gap", idx, 32'h100);
            value_ack = ack_pat[cyc % 8];
            tick();
            if (value_ack) idx++;
        end
        value_ack = 1'b0;
        if (!got_done) check_eq("gap_timeout", 1'b0, 1'b1);
        tick();
        check_eq("gap_idle", busy, 1'b0);

        // reset after the 5th transfer
        load_all(32'h200);
        start     = 1'b1;
        value_ack = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check_elem("pre_rst", 5, 32'h200);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_stb", value_stb, 1'b0);
        check_eq("async_rst_busy", busy, 1'b0);
        check_eq("async_rst_full", full, 1'b0);
        check_eq("async_rst_done", done, 1'b0);
        check_eq("async_rst_ij", {i, j}, 4'h0);
        check_eq("async_rst_value", value, 32'h0);
        value_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("after_rst_done", done, 1'b0);
        check_eq("after_rst_full", full, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("after_rst_start_stb", value_stb, 1'b0);
        check_eq("after_rst_start_done", done, 1'b0);

        load_all(32'h300);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_elem("reload", 0, 32'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 The module SHALL have parameter N, default 8, matrix dimension (N x N elements, N >= 2).
REQ-002 The module SHALL have parameter W, default 32, element width in bits.
REQ-003 The module SHALL have port clk  input  1  single clock, rising-edge active.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have port wr_en  input  1  element write strobe from the multiplier array.
REQ-006 The module SHALL have ports wr_i, wr_j  input  $clog2(N)  row and column of the written element.
REQ-007 The module SHALL have port wr_data  input  W  element value.
REQ-008 The module SHALL have port start  input  1  request to stream the buffered matrix.
REQ-009 The module SHALL have port value  output  W  element presented to the file writer.
REQ-010 The module SHALL have port value_stb  output  1  value valid; port value_ack  input  1  consumer accepted.
REQ-011 The module SHALL have ports i, j  output  $clog2(N)  row and column of the presented element.
REQ-012 The module SHALL have ports busy, full, done  output  1  each: streaming in progress, all elements loaded, end-of-matrix pulse.

Function
REQ-013 The FSM SHALL have states S_IDLE, S_STREAM and S_DONE.
REQ-014 In S_IDLE, wr_en SHALL store wr_data at [wr_i][wr_j] and set that element's valid bit; full SHALL rise the cycle after the last valid bit is set.
REQ-015 The block SHALL ignore writes with wr_i >= N or wr_j >= N; rewriting an element SHALL overwrite data and count once.
REQ-016 The block SHALL ignore wr_en in S_STREAM and S_DONE.
REQ-017 start in S_IDLE with full=1 SHALL move to S_STREAM next cycle, with i=j=0 and value_stb=1 in that first S_STREAM cycle; start with full=0 or outside S_IDLE SHALL be ignored.
REQ-018 value SHALL equal buffer[i][j] and remain stable while value_stb=1.
REQ-019 A transfer SHALL occur on a rising edge with value_stb=1 and value_ack=1; value_stb SHALL hold until acknowledged, and value_ack with value_stb=0 SHALL be ignored.
REQ-020 Order SHALL be row-major: j increments and wraps at N-1 to 0, incrementing i.
REQ-021 Transfer of element (N-1,N-1) SHALL drop value_stb and enter S_DONE next cycle.
REQ-022 S_DONE SHALL assert done for exactly one cycle, clear all valid bits (full=0 next cycle) and return to S_IDLE.
REQ-023 busy SHALL be 1 in S_STREAM and S_DONE, else 0.
REQ-024 With value_ack held high, throughput SHALL be one element per cycle and start-to-done SHALL be N*N+1 cycles.

Reset
REQ-025 rst_n low SHALL force, asynchronously, state S_IDLE; value_stb, busy, full, done, i, j, value all 0; all valid bits cleared.
REQ-026 Buffer data storage SHALL NOT be reset.
REQ-027 Reset mid-stream SHALL abort without a done pulse; a full reload SHALL be required before the next start.

Configuration
REQ-028 With RESULT_STREAMER_TRANSPOSE_EN defined, streaming order SHALL be column-major (i inner, j outer), with i, j still reporting true row and column.
REQ-029 Without RESULT_STREAMER_TRANSPOSE_EN, order SHALL be row-major per REQ-020; all other behaviour SHALL be identical.

Structure
REQ-030 Shared package matmul_pkg SHALL hold the FSM state enum, default element width constant and index-width helper function.
REQ-031 Storage SHALL be a sub-module result_buffer (N x N data array, valid bits, one write port, one combinational read port addressed by i, j).

Verification
REQ-032 N=4: load 16 elements value 16*row+col, start, ack held high -> values 0x00,0x01,..,0x33 in order, done on cycle 17 after start.
REQ-033 N=4: load 15 elements, start -> no value_stb, busy=0; write last element, start -> streaming begins.
REQ-034 Random value_ack gaps -> value, i, j stable while stb high unacked; no element dropped or duplicated.
REQ-035 rst_n low after 5th transfer -> all outputs 0 immediately, full=0, no done; later start ignored until reload.
REQ-036 TRANSPOSE_EN, N=4, same load -> order 0x00,0x10,0x20,0x30,0x01,..; wr_en during S_STREAM leaves data unchanged.
